// File: rtl/rst_seq_pkg.sv
// Shared types for the board reset sequencer.
// State encoding is exported on seq_state for debug.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    SETTLE   = 3'd1,
    WAIT_ACK = 3'd2,
    RUN      = 3'd3,
    SOFT     = 3'd4,
    FAULT    = 3'd5
  } seq_state_t;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_sync2.sv
// Two-flop reset synchronizer: async assert, sync deassert.
// rst_n_int rises on the 2nd clk edge after RST_n rises.
module rst_sync2 (
  input  logic clk,
  input  logic RST_n,
  output logic rst_n_int
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= 1'b1;
      s2_q <= s1_q;
    end
  end

  assign rst_n_int = s2_q;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: releases reset domains one at a time,
// waits for each ack, services soft resets, flags dead domains.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOM   = 3,
  parameter int STAGE_DLY = 16,
  parameter int ACK_TO    = 255,
  parameter int SOFT_HOLD = 64
) (
  input  logic               clk,
  input  logic               RST_n,
  input  logic               soft_rst_req,
  input  logic [NUM_DOM-1:0] dom_ack,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               sys_ready,
  output logic               timeout_err,
  output logic [2:0]         seq_state
);

  localparam int CW = cnt_width(STAGE_DLY, ACK_TO, SOFT_HOLD);
  localparam int IW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [CW-1:0] STG_LAST  = CW'(STAGE_DLY - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TO - 1);
  localparam logic [CW-1:0] SOFT_LAST = CW'(SOFT_HOLD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOM - 1);

  logic rst_n_int;

  seq_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_rst_n_q, dom_rst_n_d;
  logic               sys_ready_q, sys_ready_d;
  logic               timeout_err_q, timeout_err_d;

  rst_sync2 u_sync (
    .clk       (clk),
    .RST_n     (RST_n),
    .rst_n_int (rst_n_int)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    dom_rst_n_d   = dom_rst_n_q;
    sys_ready_d   = sys_ready_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      HOLD: begin
        state_d = SETTLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
      SETTLE: begin
        if (cnt_q == STG_LAST) begin
          dom_rst_n_d[idx_q] = 1'b1;
          cnt_d              = '0;
          state_d            = WAIT_ACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_ACK: begin
        if (dom_ack[idx_q]) begin
          if (idx_q == IDX_LAST) begin
            state_d     = RUN;
            sys_ready_d = 1'b1;
          end else begin
            idx_d   = idx_q + IW'(1);
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end else if (cnt_q == ACK_LAST) begin
          timeout_err_d = 1'b1;
          dom_rst_n_d   = '0;
          state_d       = FAULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        sys_ready_d = 1'b1;
        dom_rst_n_d = '1;
      end
      SOFT: begin
        if (cnt_q == SOFT_LAST) begin
          state_d = SETTLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FAULT: begin
        dom_rst_n_d = '0;
        sys_ready_d = 1'b0;
      end
      default: state_d = HOLD;
    endcase

    // A soft request overrides any same-cycle ack or timeout.
    if (soft_rst_req && state_q != HOLD) begin
      state_d       = SOFT;
      cnt_d         = '0;
      dom_rst_n_d   = '0;
      sys_ready_d   = 1'b0;
      timeout_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q       <= HOLD;
      cnt_q         <= '0;
      idx_q         <= '0;
      dom_rst_n_q   <= '0;
      sys_ready_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      dom_rst_n_q   <= dom_rst_n_d;
      sys_ready_q   <= sys_ready_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign dom_rst_n   = dom_rst_n_q;
  assign sys_ready   = sys_ready_q;
  assign timeout_err = timeout_err_q;
  assign seq_state   = state_q;

endmodule
